pool2_flatten: RTL and testbench

POOL2_FLATTEN -- requirements
Module: pool2_flatten

---
 rtl/pool2_flatten_pkg.sv | 16 +
 rtl/pool2_flatten_if.sv | 41 ++++
 rtl/pool2_flatten_flat_buf.sv | 31 +++
 rtl/pool2_flatten.sv | 171 +++++++++++++++++
 tb/tb_pool2_flatten.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pool2_flatten_pkg.sv
// pool2_flatten_pkg
// Shared CNN definitions for the pool-to-FC flatten stage: default
// geometry of the pooled feature map and the flatten FSM state encoding.
package pool2_flatten_pkg;

  localparam int CH_DEFAULT   = 12;  // channels packed per pooled word
  localparam int DW_DEFAULT   = 8;   // bits per channel element
  localparam int NPIX_DEFAULT = 64;  // pooled pixels per frame (8x8)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } flat_state_t;

endpackage

// File: rtl/pool2_flatten_if.sv
// pool2_flatten_if
// Bundles the pool-side input stream, the FC-side output stream and the
// block enable of the flatten stage.
//   en        : block enable, low aborts a frame
//   valid_in  : data_in holds one pooled pixel (all channels)
//   data_in   : CH*DW bits, channel c in [c*DW +: DW]
//   pool_end  : frame-end pulse from the pool stage
//   ready_in  : FC stage accepts data_out this cycle
//   data_out  : one flattened element
//   valid_out : data_out valid
//   flat_end  : pulse, frame fully drained
//   ovf       : pulse, an input word was dropped
// Modports: master = upstream/downstream environment, slave = flatten block.
interface pool2_flatten_if
  import pool2_flatten_pkg::*;
#(
  parameter int CH = CH_DEFAULT,
  parameter int DW = DW_DEFAULT
);

  logic             en;
  logic             valid_in;
  logic [CH*DW-1:0] data_in;
  logic             pool_end;
  logic             ready_in;
  logic [DW-1:0]    data_out;
  logic             valid_out;
  logic             flat_end;
  logic             ovf;

  modport master (
    output en, valid_in, data_in, pool_end, ready_in,
    input  data_out, valid_out, flat_end, ovf
  );

  modport slave (
    input  en, valid_in, data_in, pool_end, ready_in,
    output data_out, valid_out, flat_end, ovf
  );

endinterface

// File: rtl/pool2_flatten_flat_buf.sv
// flat_buf
// Frame buffer of the flatten stage: NPIX words of W bits, one synchronous
// write port and one combinational read port. Contents are not reset.
//   clk   : system clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module flat_buf #(
  parameter int NPIX = 64,
  parameter int W    = 96,
  parameter int AW   = $clog2(NPIX)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [NPIX];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pool2_flatten.sv
// pool2_flatten
// Collects one frame of pooled pixels (all channels per word) and re-emits
// it as a single element stream in channel-major order for the FC stage.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pool2_flatten_if.slave (en, input stream, output stream, pulses)
module pool2_flatten
  import pool2_flatten_pkg::*;
#(
  parameter int CH   = CH_DEFAULT,
  parameter int DW   = DW_DEFAULT,
  parameter int NPIX = NPIX_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  pool2_flatten_if.slave  bus
);

  localparam int AW  = $clog2(NPIX);
  localparam int WCW = AW + 1;
  localparam int CW  = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [WCW-1:0] NPIX_W = WCW'(NPIX);
  localparam logic [WCW-1:0] LAST_W = WCW'(NPIX - 1);
  localparam logic [CW-1:0]  CH_LAST = CW'(CH - 1);

  flat_state_t state, state_next;

  logic [WCW-1:0]   wr_cnt;
  logic [AW-1:0]    rd_pix;
  logic [CW-1:0]    rd_ch;
  logic             rd_done;
  logic [CH*DW-1:0] rd_word;
  logic [DW-1:0]    rd_elem;
  logic             pix_last, rd_last;

  logic             wr_en, load, accept_last, empty_end;

  logic [DW-1:0]    data_q;
  logic             valid_q, last_q, empty_end_q, run_q;

  flat_buf #(
    .NPIX (NPIX),
    .W    (CH*DW),
    .AW   (AW)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_cnt[AW-1:0]),
    .wdata (bus.data_in),
    .raddr (rd_pix),
    .rdata (rd_word)
  );

  // wr_cnt holds the number of words written, so it is also the pixel
  // count N used to wrap the read pixel index during drain.
  assign pix_last = (WCW'(rd_pix) == (wr_cnt - WCW'(1)));
  assign rd_last  = pix_last && (rd_ch == CH_LAST);

  always_comb begin
    rd_elem = '0;
    for (int c = 0; c < CH; c++) begin
      if (rd_ch == CW'(c)) rd_elem = rd_word[c*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A word coincident with pool_end is still written before draining; an
  // empty frame skips DRAIN and only reports flat_end. Dropping en
  // overrides everything and aborts without flat_end.
  always_comb begin
    state_next  = state;
    wr_en       = 1'b0;
    empty_end   = 1'b0;
    load        = 1'b0;
    accept_last = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en) state_next = FILL;
      end
      FILL: begin
        wr_en = bus.valid_in && (wr_cnt < NPIX_W);
        if (bus.pool_end && (wr_cnt == '0) && !bus.valid_in) begin
          empty_end  = 1'b1;
          state_next = IDLE;
        end else if (bus.pool_end || (wr_en && (wr_cnt == LAST_W))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        load        = !valid_q || bus.ready_in;
        accept_last = valid_q && bus.ready_in && last_q;
        if (accept_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (!bus.en) begin
      state_next  = IDLE;
      wr_en       = 1'b0;
      empty_end   = 1'b0;
      load        = 1'b0;
      accept_last = 1'b0;
    end
  end

  // Counters clear whenever the FSM heads back to IDLE so every frame
  // starts from buffer slot 0 and channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      rd_pix  <= '0;
      rd_ch   <= '0;
      rd_done <= 1'b0;
    end else if (state_next == IDLE) begin
      wr_cnt  <= '0;
      rd_pix  <= '0;
      rd_ch   <= '0;
      rd_done <= 1'b0;
    end else begin
      if (wr_en) wr_cnt <= wr_cnt + WCW'(1);
      if (load && !rd_done) begin
        if (pix_last) begin
          rd_pix <= '0;
          rd_ch  <= rd_ch + CW'(1);
        end else begin
          rd_pix <= rd_pix + AW'(1);
        end
        if (rd_last) rd_done <= 1'b1;
      end
    end
  end

  // Output register: refills when empty or accepted, holds while stalled.
  // last_q tags the final element so flat_end can fire on its acceptance.
  // run_q stays low during reset so ovf is forced to 0 there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      empty_end_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      empty_end_q <= empty_end;
      if (!bus.en || accept_last) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else if (load) begin
        if (!rd_done) begin
          data_q  <= rd_elem;
          valid_q <= 1'b1;
          last_q  <= rd_last;
        end else begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.flat_end  = empty_end_q || accept_last;
  assign bus.ovf       = run_q && bus.valid_in && (state != FILL);

endmodule

// File: tb/tb_pool2_flatten.sv
// tb_pool2_flatten
// Self-checking bench for pool2_flatten: directed frame scenarios with
// random pixel data and random/toggled backpressure, compared against a
// channel-major reference built from the words sent.
module tb_pool2_flatten;
  import pool2_flatten_pkg::*;

  localparam int CH   = CH_DEFAULT;
  localparam int DW   = DW_DEFAULT;
  localparam int NPIX = NPIX_DEFAULT;

  logic clk = 1'b0;
  logic rst_n;

  pool2_flatten_if #(.CH(CH), .DW(DW)) bus();

  pool2_flatten #(.CH(CH), .DW(DW), .NPIX(NPIX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [CH*DW-1:0] words [NPIX];

  // monitor state
  logic [DW-1:0] got [$];
  int            flat_cnt;
  int            flat_idx;
  int            ovf_cnt;
  int            stall_err;
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  // Sample in the middle of each cycle: log accepted elements, pulses and
  // any change of data/valid while a stall is in progress.
  always @(negedge clk) begin
    if (prev_stall && (bus.valid_out !== 1'b1 || bus.data_out !== prev_data))
      stall_err++;
    if (bus.valid_out === 1'b1 && bus.ready_in === 1'b1) begin
      got.push_back(bus.data_out);
      if (bus.flat_end === 1'b1) flat_idx = got.size();
    end
    if (bus.flat_end === 1'b1) flat_cnt++;
    if (bus.ovf === 1'b1) ovf_cnt++;
    prev_stall = (bus.valid_out === 1'b1) && (bus.ready_in === 1'b0);
    prev_data  = bus.data_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_monitor();
    got.delete();
    flat_cnt   = 0;
    flat_idx   = -1;
    ovf_cnt    = 0;
    stall_err  = 0;
    prev_stall = 1'b0;
  endtask

  task automatic fill_pattern(input int n);
    for (int p = 0; p < n; p++)
      for (int c = 0; c < CH; c++)
        words[p][c*DW +: DW] = DW'(p + c);
  endtask

  task automatic fill_random(input int n);
    for (int p = 0; p < n; p++)
      words[p] = {$urandom(), $urandom(), $urandom()};
  endtask

  // pe_mode 0: no pool_end, 1: pool_end with last word, 2: pool_end after
  task automatic apply_stimulus(input int n, input int pe_mode);
    bus.en = 1'b1;
    tick();
    for (int p = 0; p < n; p++) begin
      bus.valid_in = 1'b1;
      bus.data_in  = words[p];
      bus.pool_end = (pe_mode == 1) && (p == n - 1);
      tick();
    end
    bus.valid_in = 1'b0;
    bus.pool_end = 1'b0;
    if (pe_mode == 2) begin
      bus.pool_end = 1'b1;
      tick();
      bus.pool_end = 1'b0;
    end
  endtask

  // rmode 0: always ready, 1: toggle 1010..., 2: random
  task automatic wait_drain(input string tag, input int rmode);
    int cyc = 0;
    while (flat_cnt == 0 && cyc < 5000) begin
      case (rmode)
        0:       bus.ready_in = 1'b1;
        1:       bus.ready_in = ~cyc[0];
        default: bus.ready_in = 1'($urandom_range(0, 1));
      endcase
      tick();
      cyc++;
    end
    check_output({tag, "_drain_done"}, flat_cnt, 1);
    check_output({tag, "_valid_after_end"}, 32'(bus.valid_out), 0);
    bus.ready_in = 1'b1;
  endtask

  // Reference: channel-major walk over the words that were sent.
  task automatic check_stream(input string tag, input int n);
    int mism = 0;
    int exp_len = n * CH;
    logic [DW-1:0] e;
    check_output({tag, "_len"}, got.size(), exp_len);
    for (int c = 0; c < CH; c++) begin
      for (int p = 0; p < n; p++) begin
        e = words[p][c*DW +: DW];
        if ((c*n + p) < got.size() && got[c*n + p] !== e) mism++;
      end
    end
    check_output({tag, "_seq"}, mism, 0);
    check_output({tag, "_flat_idx"}, flat_idx, exp_len);
  endtask

  initial begin
    int cyc;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.valid_in = 1'b1;
    bus.data_in  = '0;
    bus.pool_end = 1'b0;
    bus.ready_in = 1'b1;
    clear_monitor();
    #12;
    check_output("rst_data_out", 32'(bus.data_out), 0);
    check_output("rst_valid_out", 32'(bus.valid_out), 0);
    check_output("rst_flat_end", 32'(bus.flat_end), 0);
    check_output("rst_ovf", 32'(bus.ovf), 0);
    bus.valid_in = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // full frame, word p channel c = p+c, always ready
    clear_monitor();
    fill_pattern(NPIX);
    apply_stimulus(NPIX, 0);
    check_output("full_valid_at_drain_entry", 32'(bus.valid_out), 0);
    tick();
    check_output("full_first_valid", 32'(bus.valid_out), 1);
    check_output("full_first_data", 32'(bus.data_out), 0);
    wait_drain("full", 0);
    check_stream("full", NPIX);
    check_output("full_elem63", 32'(got[63]), 63);
    check_output("full_elem64", 32'(got[64]), 1);
    check_output("full_elem767", 32'(got[767]), 74);
    check_output("full_ovf", ovf_cnt, 0);

    // backpressure 1010..., same pattern
    clear_monitor();
    apply_stimulus(NPIX, 0);
    wait_drain("bp", 1);
    check_stream("bp", NPIX);
    check_output("bp_stall_stable", stall_err, 0);
    check_output("bp_ovf", ovf_cnt, 0);

    // early pool_end coincident with the 10th word
    clear_monitor();
    fill_random(10);
    apply_stimulus(10, 1);
    wait_drain("early", 2);
    check_stream("early", 10);
    check_output("early_stall_stable", stall_err, 0);

    // valid_in during DRAIN for 3 cycles
    clear_monitor();
    fill_random(20);
    apply_stimulus(20, 2);
    for (int i = 0; i < 3; i++) begin
      bus.valid_in = 1'b1;
      bus.data_in  = {$urandom(), $urandom(), $urandom()};
      tick();
    end
    bus.valid_in = 1'b0;
    wait_drain("ovf", 0);
    check_stream("ovf", 20);
    check_output("ovf_pulses", ovf_cnt, 3);

    // en=0 mid-DRAIN at element 200, then a fresh frame
    clear_monitor();
    fill_random(NPIX);
    apply_stimulus(NPIX, 0);
    cyc = 0;
    while (got.size() < 200 && cyc < 2000) begin
      tick();
      cyc++;
    end
    check_output("abort_reached_200", got.size(), 200);
    bus.en = 1'b0;
    tick();
    check_output("abort_valid_off", 32'(bus.valid_out), 0);
    for (int i = 0; i < 5; i++) tick();
    check_output("abort_no_flat_end", flat_cnt, 0);
    clear_monitor();
    fill_random(16);
    apply_stimulus(16, 2);
    wait_drain("after_abort", 2);
    check_stream("after_abort", 16);

    // empty frame: pool_end with nothing written
    clear_monitor();
    apply_stimulus(0, 2);
    check_output("empty_flat_end", 32'(bus.flat_end), 1);
    check_output("empty_valid_out", 32'(bus.valid_out), 0);
    bus.valid_in = 1'b1;
    #1;
    check_output("idle_ovf", 32'(bus.ovf), 1);
    bus.valid_in = 1'b0;
    tick();
    check_output("empty_flat_end_pulse", 32'(bus.flat_end), 0);
    check_output("empty_no_data", got.size(), 0);

    // reset mid-FILL, then a normal frame
    fill_random(NPIX);
    apply_stimulus(5, 0);
    bus.valid_in = 1'b1;
    bus.data_in  = words[5];
    rst_n = 1'b0;
    #1;
    check_output("midrst_valid_out", 32'(bus.valid_out), 0);
    check_output("midrst_data_out", 32'(bus.data_out), 0);
    check_output("midrst_ovf", 32'(bus.ovf), 0);
    check_output("midrst_flat_end", 32'(bus.flat_end), 0);
    bus.valid_in = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    clear_monitor();
    fill_random(30);
    apply_stimulus(30, 1);
    wait_drain("post_rst", 2);
    check_stream("post_rst", 30);
    check_output("post_rst_stall_stable", stall_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
